// File: rtl/bitserial_pkg.sv
// Shared FSM encoding and sizing helper for the bit-serial MAC array.
package bitserial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_OUT  = 2'b10
  } state_e;

  // Bit-index counter width; a single-bit counter covers B_WIDTH of 1 or 2.
  function automatic int cnt_w(input int bw);
    return (bw > 1) ? $clog2(bw) : 1;
  endfunction

endpackage

// File: rtl/bitserial_mac_lane.sv
// One MAC lane: holds operand A, the accumulator and a sticky overflow flag.
// Each enabled cycle adds (or, for the signed MSB, subtracts) A << k when the
// serial bit is set.
module bitserial_mac_lane
  import bitserial_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int ACC_WIDTH = 40,
  parameter int KW        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic                 i_load,
  input  logic                 i_clear,
  input  logic [A_WIDTH-1:0]   i_a,
  input  logic                 i_bit,
  input  logic [KW-1:0]        i_k,
  input  logic                 i_is_msb,
  input  logic                 i_sgn,
  output logic [ACC_WIDTH-1:0] o_acc,
  output logic                 o_ovf
);

  logic [A_WIDTH-1:0]   r_a;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf;

  logic [A_WIDTH-1:0]   w_a;
  logic [ACC_WIDTH-1:0] w_ext, w_term, w_base, w_diff, w_res;
  logic [ACC_WIDTH:0]   w_add;
  logic                 w_ovf_base, w_sub, w_sovf, w_ovf_now;

  // On the accept cycle the incoming operand is used directly, since bit 0
  // is applied on the same edge that latches it.
  assign w_a        = i_load ? i_a : r_a;
  assign w_ext      = i_sgn ? {{(ACC_WIDTH-A_WIDTH){w_a[A_WIDTH-1]}}, w_a}
                            : {{(ACC_WIDTH-A_WIDTH){1'b0}}, w_a};
  assign w_term     = w_ext << i_k;
  assign w_base     = i_clear ? '0 : r_acc;
  assign w_ovf_base = i_clear ? 1'b0 : r_ovf;
  assign w_sub      = i_is_msb & i_sgn;

  assign w_add  = {1'b0, w_base} + {1'b0, w_term};
  assign w_diff = w_base - w_term;
  assign w_res  = w_sub ? w_diff : w_add[ACC_WIDTH-1:0];

  // Signed overflow: result sign disagrees with the base when the effective
  // operands shared a sign (add) or had opposite signs (subtract).
  assign w_sovf = w_sub
    ? ((w_base[ACC_WIDTH-1] != w_term[ACC_WIDTH-1]) && (w_res[ACC_WIDTH-1] != w_base[ACC_WIDTH-1]))
    : ((w_base[ACC_WIDTH-1] == w_term[ACC_WIDTH-1]) && (w_res[ACC_WIDTH-1] != w_base[ACC_WIDTH-1]));
  assign w_ovf_now = i_bit & (i_sgn ? w_sovf : w_add[ACC_WIDTH]);

  // Operand latch and per-bit accumulate with sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (i_load) r_a <= i_a;
      if (i_en) begin
        r_acc <= i_bit ? w_res : w_base;
        r_ovf <= w_ovf_base | w_ovf_now;
      end
    end
  end

  assign o_acc = r_acc;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/bitserial_mac_array.sv
// Multi-lane bit-serial multiply-accumulate engine: shared FSM, bit counter
// and handshakes; one bitserial_mac_lane per lane.
module bitserial_mac_array
  import bitserial_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int ACC_WIDTH = 40
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       signed_mode,
  input  logic                       acc_clear,
  input  logic [LANES*A_WIDTH-1:0]   a_data,
  input  logic [LANES-1:0]           b_bits,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*ACC_WIDTH-1:0] out_acc,
  output logic [LANES-1:0]           out_ovf
);

  localparam int CW = cnt_w(B_WIDTH);

  generate
    if (ACC_WIDTH < A_WIDTH + B_WIDTH) begin : g_bad_acc_width
      $error("bitserial_mac_array: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
    end
  endgenerate

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_sgn;
  logic            r_in_ready;
  logic            r_out_valid;

  logic            w_accept, w_calc, w_en, w_last, w_sgn, w_clear;
  logic [CW-1:0]   w_k;

  // r_cnt is the index of the bit applied on the previous edge; the bit being
  // applied now is one past it (bit 0 on the accept edge).
  assign w_accept = (r_state == ST_IDLE) & in_valid;
  assign w_calc   = (r_state == ST_CALC);
  assign w_en     = w_accept | w_calc;
  assign w_k      = w_accept ? '0 : (r_cnt + CW'(1));
  assign w_last   = (w_k == CW'(B_WIDTH - 1));
  assign w_sgn    = w_accept ? signed_mode : r_sgn;
  assign w_clear  = w_accept & acc_clear;

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sgn       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_cnt      <= '0;
            r_sgn      <= signed_mode;
            r_in_ready <= 1'b0;
            if (w_last) begin
              r_state     <= ST_OUT;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_cnt <= w_k;
          if (w_last) begin
            r_state     <= ST_OUT;
            r_out_valid <= 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      bitserial_mac_lane #(
        .A_WIDTH   (A_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .KW        (CW)
      ) u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_en),
        .i_load   (w_accept),
        .i_clear  (w_clear),
        .i_a      (a_data[i*A_WIDTH +: A_WIDTH]),
        .i_bit    (b_bits[i]),
        .i_k      (w_k),
        .i_is_msb (w_last),
        .i_sgn    (w_sgn),
        .o_acc    (out_acc[i*ACC_WIDTH +: ACC_WIDTH]),
        .o_ovf    (out_ovf[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_bitserial_mac_array.sv
// Self-checking bench: a 40-bit and a 32-bit accumulator instance driven by
// the same stimulus, each compared against an arithmetic reference model.
module tb_bitserial_mac_array;

  localparam int LN = 4;
  localparam int AW = 16;
  localparam int BW = 16;
  localparam int W1 = 40;
  localparam int W2 = 32;

  logic              clk = 1'b0;
  logic              rst_n, in_valid, signed_mode, acc_clear, out_ready;
  logic [LN*AW-1:0]  a_data;
  logic [LN-1:0]     b_bits;
  logic              in_ready, out_valid, in_ready2, out_valid2;
  logic [LN*W1-1:0]  out_acc;
  logic [LN*W2-1:0]  out_acc2;
  logic [LN-1:0]     out_ovf, out_ovf2;

  int checks = 0;
  int failures = 0;

  longint macc[2][LN];
  bit     movf[2][LN];
  int     ws[2] = '{W1, W2};

  always #5 clk = ~clk;

  bitserial_mac_array #(.LANES(LN), .A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(W1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .signed_mode(signed_mode), .acc_clear(acc_clear), .a_data(a_data), .b_bits(b_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf));

  bitserial_mac_array #(.LANES(LN), .A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(W2)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .signed_mode(signed_mode), .acc_clear(acc_clear), .a_data(a_data), .b_bits(b_bits),
    .out_valid(out_valid2), .out_ready(out_ready), .out_acc(out_acc2), .out_ovf(out_ovf2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: value += A * 2^k (or -= for the signed MSB), overflow judged on
  // the true mathematical result against the representable range.
  task automatic mstep(inout longint acc, inout bit ovf, input int w,
                       input logic [AW-1:0] a, input int k, input bit sgn);
    longint m, t, s, sa;
    m = longint'(1) << w;
    if (!sgn) begin
      t = longint'(a) * (longint'(1) << k);
      s = acc + t;
      if (s >= m) ovf = 1'b1;
      acc = s % m;
    end else begin
      sa = (acc >= m / 2) ? acc - m : acc;
      t  = longint'($signed(a)) * (longint'(1) << k);
      s  = (k == BW - 1) ? sa - t : sa + t;
      if (s >= m / 2 || s < -(m / 2)) ovf = 1'b1;
      acc = ((s % m) + m) % m;
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < LN; i++) begin
        macc[d][i] = 0;
        movf[d][i] = 1'b0;
      end
  endtask

  task automatic check_results(input string tag);
    logic [LN-1:0] e0, e1;
    for (int i = 0; i < LN; i++) begin
      chk({tag, "_acc40"}, 64'(out_acc[i*W1 +: W1]), 64'(macc[0][i][W1-1:0]));
      chk({tag, "_acc32"}, 64'(out_acc2[i*W2 +: W2]), 64'(macc[1][i][W2-1:0]));
      e0[i] = movf[0][i];
      e1[i] = movf[1][i];
    end
    chk({tag, "_ovf40"}, 64'(out_ovf), 64'(e0));
    chk({tag, "_ovf32"}, 64'(out_ovf2), 64'(e1));
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_wait_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Full operation: accept, serial bits, latency check, result check,
  // optional backpressure, then handoff.
  task automatic run_op(input logic [LN-1:0][AW-1:0] a, input logic [LN-1:0][AW-1:0] b,
                        input bit sgn, input bit clr, input int hold, input string tag);
    logic [LN*W1-1:0] held;
    wait_ready(tag);
    if (clr) model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < LN; i++)
        for (int k = 0; k < BW; k++)
          if (b[i][k]) mstep(macc[d][i], movf[d][i], ws[d], a[i], k, sgn);
    in_valid = 1'b1; signed_mode = sgn; acc_clear = clr; a_data = a;
    for (int i = 0; i < LN; i++) b_bits[i] = b[i][0];
    @(posedge clk); #1;
    in_valid = 1'b0; acc_clear = $urandom_range(0, 1) != 0;
    signed_mode = ~sgn; a_data = {$urandom(), $urandom()};
    for (int k = 1; k < BW; k++) begin
      chk({tag, "_early_valid"}, 64'(out_valid), 64'd0);
      for (int i = 0; i < LN; i++) b_bits[i] = b[i][k];
      @(posedge clk); #1;
    end
    b_bits = 4'($urandom());
    chk({tag, "_latency"}, 64'(out_valid), 64'd1);
    chk({tag, "_latency32"}, 64'(out_valid2), 64'd1);
    chk({tag, "_busy"}, 64'(in_ready), 64'd0);
    check_results(tag);
    held = out_acc;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a_data = {$urandom(), $urandom()};
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_hold_acc"}, 64'(out_acc[63:0] ^ held[63:0]), 64'd0);
    end
    in_valid = 1'b0;
    if (hold > 0) check_results({tag, "_held"});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_handoff_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_handoff_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [LN-1:0][AW-1:0] a, b;

    rst_n = 1'b0; in_valid = 1'b0; signed_mode = 1'b0; acc_clear = 1'b0;
    out_ready = 1'b0; a_data = '0; b_bits = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    check_results("reset");
    rst_n = 1'b1;

    // 1: unsigned 3*5 from clear
    for (int i = 0; i < LN; i++) begin a[i] = 16'd3; b[i] = 16'd5; end
    run_op(a, b, 1'b0, 1'b1, 0, "t1");
    chk("t1_const", 64'(out_acc[W1-1:0]), 64'd15);

    // 2: accumulate 7*2 onto 15
    for (int i = 0; i < LN; i++) begin a[i] = 16'd7; b[i] = 16'd2; end
    run_op(a, b, 1'b0, 1'b0, 0, "t2");
    chk("t2_const", 64'(out_acc[2*W1-1:W1]), 64'd29);
    chk("t2_ovf", 64'(out_ovf), 64'd0);

    // 3: signed corner products
    a[0] = 16'hFFFD; b[0] = 16'hFFFE;
    a[1] = 16'h8000; b[1] = 16'h7FFF;
    a[2] = 16'(($urandom())); b[2] = 16'($urandom());
    a[3] = 16'h8000; b[3] = 16'h8000;
    run_op(a, b, 1'b1, 1'b1, 0, "t3");
    chk("t3_lane0", 64'(out_acc[W1-1:0]), 64'd6);
    chk("t3_lane1", 64'(out_acc[2*W1-1:W1]), 64'hFF_C000_8000);

    // 4: backpressure with ignored in_valid pulses
    for (int i = 0; i < LN; i++) begin a[i] = 16'($urandom()); b[i] = 16'($urandom()); end
    run_op(a, b, 1'b0, 1'b1, 5, "t4");

    // 5: 32-bit accumulator wraps and flags, then clear drops the flag
    for (int i = 0; i < LN; i++) begin a[i] = 16'hFFFF; b[i] = 16'hFFFF; end
    run_op(a, b, 1'b0, 1'b1, 0, "t5a");
    run_op(a, b, 1'b0, 1'b0, 0, "t5b");
    chk("t5_wrap", 64'(out_acc2[W2-1:0]), 64'hFFFC_0002);
    chk("t5_ovf", 64'(out_ovf2), 64'hF);
    for (int i = 0; i < LN; i++) begin a[i] = 16'd1; b[i] = 16'd1; end
    run_op(a, b, 1'b0, 1'b1, 0, "t5c");
    chk("t5_ovf_cleared", 64'(out_ovf2), 64'h0);

    // Randomized operations against the model
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < LN; i++) begin a[i] = 16'($urandom()); b[i] = 16'($urandom()); end
      run_op(a, b, $urandom_range(0, 1) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2), "rnd");
    end

    // 6: reset in the middle of a calculation
    wait_ready("t6");
    in_valid = 1'b1; acc_clear = 1'b0; signed_mode = 1'b0;
    a_data = {$urandom(), $urandom()}; b_bits = 4'hF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    check_results("t6");
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_result", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
